sdram_device_responder: RTL and testbench

Single-chip, synthesizable SDR SDRAM responder model for the far end of the 4-channel auto-precharge controller's memory bus.
- Decodes CS/RAS/CAS/WE commands and tracks per-bank open rows.
- Stores write data in an internal word array and returns read data after the programmed CAS latency.
- Flags protocol and timing violations as sticky errors, so controller benches (and FPGA loopback builds) can self-check.

---
 rtl/sdram_device_responder.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_sdram_device_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_device_responder.sv
// Single-chip SDR SDRAM responder: decodes commands, tracks per-bank open rows
// and timers, stores written words and returns read data after the CAS latency.
// Protocol and timing violations are latched into sticky error flags.
module sdram_device_responder #(
    parameter int MEM_AW   = 16,
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 9,
    parameter int CAS_LAT  = 2,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  ba,
    input  logic [12:0] addr,
    inout  wire  [15:0] dq,
    input  logic [1:0]  dqm,
    output logic        init_done,
    output logic        err_protocol,
    output logic        err_timing,
    output logic [15:0] refresh_count
);

    localparam int T_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                          : ((T_RP > T_RFC) ? T_RP : T_RFC);
    localparam int TW = $clog2(T_MAX) + 1;
    localparam logic [TW-1:0] T_SAT   = '1;
    localparam logic [TW-1:0] RCD_MIN = TW'(T_RCD);
    localparam logic [TW-1:0] RP_MIN  = TW'(T_RP);
    localparam logic [TW-1:0] RFC_MIN = TW'(T_RFC);

    typedef enum logic [2:0] {
        WAIT_PALL,
        WAIT_REF1,
        WAIT_REF2,
        WAIT_MRS,
        READY
    } init_state_t;

    init_state_t state_reg, state_next;

    // Timers restart at 1 so that a command exactly T cycles later sees T.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == T_SAT) ? t : t + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       is_mrs, is_ref, is_pre, is_act, is_wr, is_rd, non_nop;

    // Decode the sampled command pins; cke low or cs_n high means no command.
    always_comb begin
        cmd_valid = cke && !cs_n;
        cmd       = {ras_n, cas_n, we_n};
        is_mrs    = cmd_valid && (cmd == 3'b000);
        is_ref    = cmd_valid && (cmd == 3'b001);
        is_pre    = cmd_valid && (cmd == 3'b010);
        is_act    = cmd_valid && (cmd == 3'b011);
        is_wr     = cmd_valid && (cmd == 3'b100);
        is_rd     = cmd_valid && (cmd == 3'b101);
        non_nop   = cmd_valid && (cmd != 3'b111);
    end

    // ------------------------------------------------------------------
    // Per-bank state: open flag, open row, RCD and RP timers
    // ------------------------------------------------------------------
    logic [3:0]          bank_open;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [TW-1:0]       bank_rcd [4];
    logic [TW-1:0]       bank_rp  [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic                open_reg;
        logic [ROW_BITS-1:0] row_reg;
        logic [TW-1:0]       rcd_reg;
        logic [TW-1:0]       rp_reg;
        logic                hit;

        assign hit          = (ba == 2'(gi));
        assign bank_open[gi] = open_reg;
        assign bank_row[gi]  = row_reg;
        assign bank_rcd[gi]  = rcd_reg;
        assign bank_rp[gi]   = rp_reg;

        // Open/close tracking with timer restarts; later assignments override the increment.
        always_ff @(posedge clk) begin
            if (reset) begin
                open_reg <= 1'b0;
                row_reg  <= '0;
                rcd_reg  <= T_SAT;
                rp_reg   <= T_SAT;
            end else if (cke) begin
                rcd_reg <= sat_inc(rcd_reg);
                rp_reg  <= sat_inc(rp_reg);
                if (is_pre && (addr[10] || hit)) begin
                    open_reg <= 1'b0;
                    rp_reg   <= TW'(1);
                end
                if (is_act && hit && !open_reg) begin
                    open_reg <= 1'b1;
                    row_reg  <= addr[ROW_BITS-1:0];
                    rcd_reg  <= TW'(1);
                end
                if ((is_rd || is_wr) && hit && open_reg && addr[10]) begin
                    open_reg <= 1'b0;
                    rp_reg   <= TW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh timer, refresh counter, CAS latency register
    // ------------------------------------------------------------------
    logic [TW-1:0] rfc_timer_reg;
    logic [15:0]   refresh_count_reg;
    logic [1:0]    cl_reg;
    logic          cl_field_ok;

    assign cl_field_ok = (addr[6:4] == 3'd2) || (addr[6:4] == 3'd3);

    // Refresh bookkeeping and mode register latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            rfc_timer_reg     <= T_SAT;
            refresh_count_reg <= '0;
            cl_reg            <= 2'(CAS_LAT);
        end else if (cke) begin
            rfc_timer_reg <= sat_inc(rfc_timer_reg);
            if (is_ref) begin
                rfc_timer_reg     <= TW'(1);
                refresh_count_reg <= refresh_count_reg + 16'd1;
            end
            if (is_mrs && cl_field_ok) begin
                cl_reg <= addr[5:4];
            end
        end
    end

    assign refresh_count = refresh_count_reg;

    // ------------------------------------------------------------------
    // Initialization FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WAIT_PALL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Advance through PALL, two REFRESHes and MRS in order.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_PALL: if (is_pre && addr[10]) state_next = WAIT_REF1;
            WAIT_REF1: if (is_ref)             state_next = WAIT_REF2;
            WAIT_REF2: if (is_ref)             state_next = WAIT_MRS;
            WAIT_MRS:  if (is_mrs)             state_next = READY;
            READY:                             state_next = READY;
            default:                           state_next = WAIT_PALL;
        endcase
    end

    assign init_done = (state_reg == READY);

    // ------------------------------------------------------------------
    // Read pipeline state (declared early: the write turnaround check needs it)
    // ------------------------------------------------------------------
    logic [2:0]  pipe_valid_reg;
    logic [1:0]  pipe_dqm0_reg, pipe_dqm1_reg, pipe_dqm2_reg;
    logic [15:0] pipe_data1_reg, pipe_data2_reg;
    logic        out_valid_reg;
    logic [1:0]  out_dqm_reg;
    logic [15:0] out_data_reg;
    logic        rd_pending;

    assign rd_pending = (cl_reg == 2'd3) ? (|pipe_valid_reg) : (|pipe_valid_reg[1:0]);

    // ------------------------------------------------------------------
    // Violation detection and sticky error flags
    // ------------------------------------------------------------------
    logic target_open;
    logic prot_viol, timing_viol;
    logic err_protocol_reg, err_timing_reg;

    // Classify this cycle's command against bank state, init state and timers.
    always_comb begin
        target_open = bank_open[ba];
        prot_viol   = 1'b0;
        timing_viol = 1'b0;
        if ((is_act || is_rd || is_wr) && (state_reg != READY)) prot_viol = 1'b1;
        if (is_mrs && ((|bank_open) || !cl_field_ok || (addr[2:0] != 3'b000))) prot_viol = 1'b1;
        if (is_act && target_open) prot_viol = 1'b1;
        if ((is_rd || is_wr) && !target_open) prot_viol = 1'b1;
        if (is_wr && rd_pending) prot_viol = 1'b1;
        if (is_ref && (|bank_open)) prot_viol = 1'b1;
        if (is_act && !target_open && (bank_rp[ba] < RP_MIN)) timing_viol = 1'b1;
        if ((is_rd || is_wr) && target_open && (bank_rcd[ba] < RCD_MIN)) timing_viol = 1'b1;
        if (non_nop && (rfc_timer_reg < RFC_MIN)) timing_viol = 1'b1;
    end

    // Errors stay set until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_protocol_reg <= 1'b0;
            err_timing_reg   <= 1'b0;
        end else begin
            if (prot_viol)   err_protocol_reg <= 1'b1;
            if (timing_viol) err_timing_reg   <= 1'b1;
        end
    end

    assign err_protocol = err_protocol_reg;
    assign err_timing   = err_timing_reg;

    // ------------------------------------------------------------------
    // Word storage: one byte-wide array per lane, registered read
    // ------------------------------------------------------------------
    logic              wr_en, rd_en;
    logic [MEM_AW-1:0] mem_idx;
    logic [15:0]       rd_word;

    assign wr_en   = is_wr && target_open;
    assign rd_en   = is_rd && target_open;
    assign mem_idx = MEM_AW'({ba, bank_row[ba], addr[COL_BITS-1:0]});

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] mem [0:(1 << MEM_AW) - 1];
        logic [7:0] lane_q;

        // Masked byte write and registered read; contents survive reset.
        always_ff @(posedge clk) begin
            if (wr_en && !dqm[gi]) begin
                mem[mem_idx] <= dq[gi*8 +: 8];
            end
            if (rd_en) begin
                lane_q <= mem[mem_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_q;
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 holds the command, the word joins at stage 1,
    // and the output register presents it CL edges after the READ.
    // ------------------------------------------------------------------
    // Shift the pipeline while cke is high; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else if (cke) begin
            pipe_valid_reg <= {pipe_valid_reg[1:0], rd_en};
            out_valid_reg  <= (cl_reg == 2'd3) ? pipe_valid_reg[2] : pipe_valid_reg[1];
        end
    end

    // Data and masks follow the valid bits; no reset needed.
    always_ff @(posedge clk) begin
        if (cke) begin
            pipe_dqm0_reg  <= dqm;
            pipe_dqm1_reg  <= pipe_dqm0_reg;
            pipe_dqm2_reg  <= pipe_dqm1_reg;
            pipe_data1_reg <= rd_word;
            pipe_data2_reg <= pipe_data1_reg;
            out_dqm_reg    <= (cl_reg == 2'd3) ? pipe_dqm2_reg  : pipe_dqm1_reg;
            out_data_reg   <= (cl_reg == 2'd3) ? pipe_data2_reg : pipe_data1_reg;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_drive
        assign dq[gi*8 +: 8] = (out_valid_reg && !out_dqm_reg[gi]) ? out_data_reg[gi*8 +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder: read data is scoreboarded by due
// cycle and checked on the falling edge; status outputs are checked inline.
module tb_sdram_device_responder;

    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b1;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] addr = '0;
    logic [1:0]  dqm = '0;
    logic [15:0] dq_drv = '0;
    logic        dq_oe = 1'b0;
    wire  [15:0] dq;
    logic        init_done, err_protocol, err_timing;
    logic [15:0] refresh_count;

    int  cyc = 0;
    int  total = 0;
    int  passed = 0;
    int  failed = 0;
    bit  mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    assign dq = dq_oe ? dq_drv : 16'bz;
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (dq[gi]);
    end

    sdram_device_responder dut (
        .clk           (clk),
        .reset         (reset),
        .cke           (cke),
        .cs_n          (cs_n),
        .ras_n         (ras_n),
        .cas_n         (cas_n),
        .we_n          (we_n),
        .ba            (ba),
        .addr          (addr),
        .dq            (dq),
        .dqm           (dqm),
        .init_done     (init_done),
        .err_protocol  (err_protocol),
        .err_timing    (err_timing),
        .refresh_count (refresh_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus monitor: scheduled read data on its due cycle, pulled-up idle otherwise.
    always @(negedge clk) begin
        if (mon_en && !dq_oe) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", {16'h0, dq}, {16'h0, e.val});
                $display("read  cycle=%0d dq=%h expected=%h", cyc, dq, e.val);
            end else begin
                chk("dq_idle", {16'h0, dq}, 32'h0000_FFFF);
            end
        end
    end

    // Present one command for exactly one edge, then return to deselect.
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [1:0] m, input logic [15:0] d, input bit drv);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        dqm = m;
        dq_drv = d;
        dq_oe = drv;
        $display("cmd   edge=%0d rcw=%b ba=%0d addr=%h dqm=%b dq=%h", cyc + 1, c, b, a, m, d);
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        dq_oe = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] b, input logic [12:0] a, input logic [1:0] m,
                      input logic [15:0] exp, input int lat);
        exp_t e;
        e.due = cyc + 1 + lat;
        e.val = exp;
        sb.push_back(e);
        issue(C_RD, b, a, m, 16'h0, 1'b0);
    endtask

    initial begin
        // Reset state
        nop(2);
        chk("rst_init_done", {31'h0, init_done}, 32'h0);
        chk("rst_err_protocol", {31'h0, err_protocol}, 32'h0);
        chk("rst_err_timing", {31'h0, err_timing}, 32'h0);
        chk("rst_refresh_count", {16'h0, refresh_count}, 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Initialization: PALL, REF, REF, MRS CL2
        issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0, 1'b0);
        issue(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0, 1'b0);
        nop(6);
        issue(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0, 1'b0);
        nop(6);
        chk("pre_mrs_init_done", {31'h0, init_done}, 32'h0);
        issue(C_MRS, 2'd0, 13'h0020, 2'b00, 16'h0, 1'b0);
        chk("init_done", {31'h0, init_done}, 32'h1);
        chk("init_err_protocol", {31'h0, err_protocol}, 32'h0);
        chk("init_err_timing", {31'h0, err_timing}, 32'h0);
        chk("init_refresh_count", {16'h0, refresh_count}, 32'd2);

        // Basic write then read, CL2
        issue(C_ACT, 2'd0, 13'h0001, 2'b00, 16'h0, 1'b0);
        nop(1);
        issue(C_WR, 2'd0, 13'h0100, 2'b00, 16'h1234, 1'b1);
        rd(2'd0, 13'h0100, 2'b00, 16'h1234, 2);
        nop(3);
        chk("wr_rd_err_protocol", {31'h0, err_protocol}, 32'h0);
        chk("wr_rd_err_timing", {31'h0, err_timing}, 32'h0);

        // Auto-precharge: legal reopen after T_RP, then a too-early reopen
        issue(C_ACT, 2'd1, 13'h0000, 2'b00, 16'h0, 1'b0);
        nop(1);
        issue(C_WR, 2'd1, 13'h0400, 2'b00, 16'h2345, 1'b1);
        nop(1);
        issue(C_ACT, 2'd1, 13'h0000, 2'b00, 16'h0, 1'b0);
        chk("ap_ok_err_timing", {31'h0, err_timing}, 32'h0);
        chk("ap_ok_err_protocol", {31'h0, err_protocol}, 32'h0);
        nop(1);
        rd(2'd1, 13'h0400, 2'b00, 16'h2345, 2);
        issue(C_ACT, 2'd1, 13'h0000, 2'b00, 16'h0, 1'b0);
        chk("ap_early_err_timing", {31'h0, err_timing}, 32'h1);
        chk("ap_early_err_protocol", {31'h0, err_protocol}, 32'h0);
        nop(3);

        // Byte masking on write and read
        issue(C_WR, 2'd0, 13'h0100, 2'b01, 16'hABCD, 1'b1);
        rd(2'd0, 13'h0100, 2'b00, 16'hAB34, 2);
        rd(2'd0, 13'h0100, 2'b10, 16'hFF34, 2);
        nop(3);
        chk("mask_err_protocol", {31'h0, err_protocol}, 32'h0);

        // Switch to CL3 and read back
        issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0, 1'b0);
        issue(C_MRS, 2'd0, 13'h0030, 2'b00, 16'h0, 1'b0);
        chk("cl3_mrs_err_protocol", {31'h0, err_protocol}, 32'h0);
        issue(C_ACT, 2'd0, 13'h0001, 2'b00, 16'h0, 1'b0);
        nop(1);
        rd(2'd0, 13'h0100, 2'b00, 16'hAB34, 3);
        nop(4);

        // Read on a closed bank: protocol error, bus stays idle
        issue(C_RD, 2'd2, 13'h0100, 2'b00, 16'h0, 1'b0);
        nop(4);
        chk("closed_rd_err_protocol", {31'h0, err_protocol}, 32'h1);

        // Reset one cycle after a CL3 read: data must never appear
        issue(C_RD, 2'd0, 13'h0100, 2'b00, 16'h0, 1'b0);
        reset = 1'b1;
        nop(1);
        reset = 1'b0;
        chk("rst2_init_done", {31'h0, init_done}, 32'h0);
        chk("rst2_refresh_count", {16'h0, refresh_count}, 32'h0);
        chk("rst2_err_protocol", {31'h0, err_protocol}, 32'h0);
        chk("rst2_err_timing", {31'h0, err_timing}, 32'h0);
        nop(5);

        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
